// File: rtl/regfile_access_ctrl.sv
// Sequencing controller for a 1R/1W register file: accepts one operation over a
// valid/ready request channel, issues the reads/writes, and returns results.
module regfile_access_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_rn,
  input  logic [ADDR_W-1:0] req_rm,
  input  logic [ADDR_W-1:0] req_rd,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] rf_readnum,
  input  logic [DATA_W-1:0] rf_data_out,
  output logic [ADDR_W-1:0] rf_writenum,
  output logic              rf_write,
  output logic [DATA_W-1:0] rf_data_in,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_a,
  output logic [DATA_W-1:0] rsp_b,
  output logic [7:0]        txn_count
);

  localparam logic [1:0] OP_READ2 = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ1 = 2'b10;
  localparam logic [1:0] OP_MOVE  = 2'b11;

  typedef enum logic [2:0] {IDLE, RDA, RDB, WR, RSP} state_t;

  state_t            state, state_next;
  logic [1:0]        op_reg;
  logic [ADDR_W-1:0] rn_reg, rm_reg, rd_reg;
  logic [DATA_W-1:0] wdata_reg, a_reg, b_reg;
  logic [7:0]        count_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req_valid) state_next = (req_op == OP_WRITE) ? WR : RDA;
      RDA: begin
        case (op_reg)
          OP_READ2: state_next = RDB;
          OP_MOVE:  state_next = WR;
          default:  state_next = RSP;
        endcase
      end
      RDB:     state_next = RSP;
      WR:      state_next = RSP;
      RSP:     if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand/result registers; MOVE routes the read value into wdata_reg for its WR cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_reg    <= '0;
      rn_reg    <= '0;
      rm_reg    <= '0;
      rd_reg    <= '0;
      wdata_reg <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      count_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_reg    <= req_op;
            rn_reg    <= req_rn;
            rm_reg    <= req_rm;
            rd_reg    <= req_rd;
            wdata_reg <= req_wdata;
          end
        end
        RDA: begin
          a_reg <= rf_data_out;
          if (op_reg == OP_MOVE) wdata_reg <= rf_data_out;
        end
        RDB:     b_reg <= rf_data_out;
        WR:      a_reg <= wdata_reg;
        RSP:     if (rsp_ready) count_reg <= count_reg + 8'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready   = 1'b0;
    rf_readnum  = '0;
    rf_writenum = '0;
    rf_write    = 1'b0;
    rf_data_in  = '0;
    rsp_valid   = 1'b0;
    rsp_a       = '0;
    rsp_b       = '0;
    case (state)
      IDLE: req_ready  = 1'b1;
      RDA:  rf_readnum = (op_reg == OP_MOVE) ? rm_reg : rn_reg;
      RDB:  rf_readnum = rm_reg;
      WR: begin
        // Gated by reset so a reset landing on the WR cycle never corrupts the file.
        rf_write    = reset_n;
        rf_writenum = rd_reg;
        rf_data_in  = wdata_reg;
      end
      RSP: begin
        rsp_valid = 1'b1;
        rsp_a     = a_reg;
        rsp_b     = (op_reg == OP_READ2) ? b_reg : '0;
      end
      default: ;
    endcase
  end

  assign txn_count = count_reg;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: directed and random operations against an array
// model of the register contents, with a behavioural register file on the rf_* ports.
module tb_regfile_access_ctrl;

  localparam logic [1:0] OP_READ2 = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ1 = 2'b10;
  localparam logic [1:0] OP_MOVE  = 2'b11;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [2:0]  req_rn = '0, req_rm = '0, req_rd = '0;
  logic [15:0] req_wdata = '0;
  logic [2:0]  rf_readnum, rf_writenum;
  logic [15:0] rf_data_out, rf_data_in;
  logic        rf_write;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_a, rsp_b;
  logic [7:0]  txn_count;

  int tests = 0;
  int fails = 0;

  logic [15:0] rf_mem [8];
  logic [15:0] ref_rf [8];
  logic [7:0]  cnt = '0;
  int          wr_cycles = 0;
  logic [2:0]  last_wn = '0;

  always #5 clk = ~clk;

  regfile_access_ctrl #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rn(req_rn), .req_rm(req_rm), .req_rd(req_rd), .req_wdata(req_wdata),
    .rf_readnum(rf_readnum), .rf_data_out(rf_data_out), .rf_writenum(rf_writenum),
    .rf_write(rf_write), .rf_data_in(rf_data_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_a(rsp_a), .rsp_b(rsp_b),
    .txn_count(txn_count)
  );

  // Register file: combinational read, write at the rising edge.
  assign rf_data_out = rf_mem[rf_readnum];
  always @(posedge clk) if (rf_write) rf_mem[rf_writenum] <= rf_data_in;

  always @(negedge clk) begin
    if (rf_write) begin
      wr_cycles <= wr_cycles + 1;
      last_wn   <= rf_writenum;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction; hold = cycles to keep rsp_ready low once the response appears.
  task automatic txn(input logic [1:0] op, input logic [2:0] rn, input logic [2:0] rm,
                     input logic [2:0] rd, input logic [15:0] wd, input int hold);
    logic [15:0] ea, eb;
    int el, lat, w0, ew;
    bit seen;
    case (op)
      OP_READ2: begin ea = ref_rf[rn]; eb = ref_rf[rm]; end
      OP_READ1: begin ea = ref_rf[rn]; eb = 16'h0; end
      OP_WRITE: begin ea = wd; eb = 16'h0; ref_rf[rd] = wd; end
      default:  begin ea = ref_rf[rm]; eb = 16'h0; ref_rf[rd] = ea; end
    endcase
    el = (op == OP_READ2 || op == OP_MOVE) ? 3 : 2;
    ew = (op == OP_WRITE || op == OP_MOVE) ? 1 : 0;
    @(negedge clk);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    w0 = wr_cycles;
    req_valid = 1'b1; req_op = op; req_rn = rn; req_rm = rm; req_rd = rd; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_rn = 3'($urandom); req_rm = 3'($urandom); req_rd = 3'($urandom);
    req_wdata = 16'($urandom);
    rsp_ready = (hold == 0);
    lat = 0; seen = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = i; seen = 1; break; end
    end
    check("latency", lat, el);
    if (seen) begin
      for (int i = 0; i < hold; i++) begin
        check("hold_valid", rsp_valid, 1);
        check("hold_a", rsp_a, ea);
        check("hold_b", rsp_b, eb);
        check("hold_req_ready", req_ready, 0);
        check("hold_count", txn_count, cnt);
        @(negedge clk);
      end
      rsp_ready = 1'b1;
      check("rsp_a", rsp_a, ea);
      check("rsp_b", rsp_b, eb);
      @(posedge clk);
      @(negedge clk);
      cnt = cnt + 8'd1;
      check("txn_count", txn_count, cnt);
      check("rsp_valid_done", rsp_valid, 0);
      check("write_cycles", wr_cycles - w0, ew);
      if (ew == 1) check("writenum", last_wn, rd);
    end
  endtask

  initial begin
    int w0;
    // Reset held for two edges.
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_txn_count", txn_count, 0);
    check("rst_rf_write", rf_write, 0);
    check("rst_rsp_a", rsp_a, 0);
    check("rst_rsp_b", rsp_b, 0);
    check("rst_readnum", rf_readnum, 0);
    check("rst_writenum", rf_writenum, 0);
    check("rst_data_in", rf_data_in, 0);

    txn(OP_WRITE, 3'd0, 3'd0, 3'd3, 16'hBEEF, 0);
    txn(OP_READ1, 3'd3, 3'd0, 3'd0, 16'h0, 0);
    check("count_two", txn_count, 8'd2);

    // Load every register so later reads have known contents.
    for (int r = 0; r < 8; r++) if (r != 3) txn(OP_WRITE, 3'd0, 3'd0, 3'(r), 16'($urandom), 0);

    txn(OP_WRITE, 3'd0, 3'd0, 3'd1, 16'h0011, 0);
    txn(OP_WRITE, 3'd0, 3'd0, 3'd2, 16'h0022, 0);
    txn(OP_READ2, 3'd1, 3'd2, 3'd0, 16'h0, 0);
    txn(OP_MOVE, 3'd0, 3'd1, 3'd7, 16'h0, 0);
    txn(OP_READ1, 3'd7, 3'd0, 3'd0, 16'h0, 0);
    txn(OP_READ1, 3'd1, 3'd0, 3'd0, 16'h0, 0);
    txn(OP_READ2, 3'd5, 3'd5, 3'd0, 16'h0, 0);
    txn(OP_MOVE, 3'd0, 3'd6, 3'd6, 16'h0, 0);
    txn(OP_READ1, 3'd6, 3'd0, 3'd0, 16'h0, 0);
    txn(OP_READ1, 3'd3, 3'd0, 3'd0, 16'h0, 5);

    // Reset lands on the WR cycle of a WRITE to R4.
    @(negedge clk);
    w0 = wr_cycles;
    req_valid = 1'b1; req_op = OP_WRITE; req_rd = 3'd4; req_wdata = 16'h1234;
    @(posedge clk);
    #1 req_valid = 1'b0; reset_n = 1'b0;
    @(negedge clk);
    check("wr_reset_rf_write", rf_write, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    cnt = '0;
    check("wr_reset_no_write", wr_cycles - w0, 0);
    check("wr_reset_req_ready", req_ready, 1);
    check("wr_reset_rsp_valid", rsp_valid, 0);
    check("wr_reset_count", txn_count, 0);
    txn(OP_READ1, 3'd4, 3'd0, 3'd0, 16'h0, 0);

    for (int i = 0; i < 60; i++)
      txn(2'($urandom_range(0, 3)), 3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom), 0);

    // Counter wrap: 256 transactions from reset.
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    cnt = '0;
    for (int i = 0; i < 256; i++)
      txn(($urandom_range(0, 1) == 0) ? OP_READ1 : OP_WRITE,
          3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom), 0);
    check("count_wrap", txn_count, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
